// File: rtl/uart_tx_feeder_if.sv
// Push-side and transmitter-side signals of uart_tx_feeder.
// The level signal exists only with UART_TX_FEEDER_LEVEL_EN.
interface uart_tx_feeder_if #(
  parameter int AW = 4
);
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        ovf_clr;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_done;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [AW:0] level;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_done,
    input  full, empty, overflow,
    input  tx_byte, tx_start, level
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_done,
    output full, empty, overflow,
    output tx_byte, tx_start, level
  );
`else
  modport master (
    output wr_en, wr_data, ovf_clr, tx_done,
    input  full, empty, overflow,
    input  tx_byte, tx_start
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_done,
    output full, empty, overflow,
    output tx_byte, tx_start
  );
`endif
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus start/done launch FSM feeding a UART transmitter.
// Define UART_TX_FEEDER_LEVEL_EN to expose the fill count on bus.level.
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_start_q, tx_start_d;
  logic          ovf_q, ovf_d;
  logic          full;
  logic          push;
  logic          pop;

  // Full uses the pre-edge count, so a same-cycle pop never rescues a push.
  assign full = (cnt_q == FULL_CNT);
  assign push = bus.wr_en & ~full;
  assign pop  = (state_q == LAUNCH);

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) state_d = LAUNCH;
      end
      LAUNCH: begin
        tx_start_d = 1'b1;
        tx_byte_d  = mem_q[rd_ptr_q];
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (bus.wr_en & full) ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full     = full;
  assign bus.empty    = (cnt_q == '0);
  assign bus.overflow = ovf_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_start = tx_start_q;
`ifdef UART_TX_FEEDER_LEVEL_EN
  assign bus.level    = cnt_q;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue model, model transmitter, directed table.
// Honours UART_TX_FEEDER_LEVEL_EN for the level checks.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic clk;
  logic rst_n;

  uart_tx_feeder_if #(.AW(AW)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       clr;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t tbl [21];

  int ncmp = 0;
  int nfail = 0;
  int e = 0;
  int expect_at = -1;
  int j = 0;
  int cd = 1;
  int ch = 1;
  int xd = 10;
  int xh = 2;
  int nstarts = 0;
  bit rnd = 0;
  bit busy = 0;
  bit free_m = 1;
  bit ovf_m = 0;
  bit force_done = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy = 0;
    free_m = 1;
    ovf_m = 0;
    expect_at = -1;
    bus.tx_done = 1'b0;
  endtask

  task automatic cycle(input logic we, input logic [7:0] wd,
                       input logic clr);
    int pre;
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.ovf_clr = clr;
    @(posedge clk);
    #1;
    e++;
    pre = q.size();
    chk("tx_start", {31'd0, bus.tx_start}, {31'd0, expect_at == e});
    if (bus.tx_start === 1'b1) begin
      nstarts++;
      if (q.size() == 0) begin
        chk("launch_from_empty", 32'd1, 32'd0);
      end else begin
        cur_byte = q.pop_front();
        chk("tx_byte", {24'd0, bus.tx_byte}, {24'd0, cur_byte});
      end
      busy = 1;
      free_m = 0;
      j = 0;
      expect_at = -1;
      cd = rnd ? int'($urandom_range(1, 15)) : xd;
      ch = rnd ? int'($urandom_range(1, 4)) : xh;
    end else if (busy) begin
      chk("tx_byte_hold", {24'd0, bus.tx_byte}, {24'd0, cur_byte});
      j++;
      if (j == cd + ch + 1) begin
        busy = 0;
        free_m = 1;
      end
    end
    if (we && pre < DEPTH) q.push_back(wd);
    if (we && pre == DEPTH) ovf_m = 1;
    else if (clr) ovf_m = 0;
    if (free_m && q.size() != 0) begin
      expect_at = e + 2;
      free_m = 0;
    end
    bus.tx_done = force_done | (busy && j >= cd && j < cd + ch);
    chk("full", {31'd0, bus.full}, {31'd0, q.size() == DEPTH});
    chk("empty", {31'd0, bus.empty}, {31'd0, q.size() == 0});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, ovf_m});
`ifdef UART_TX_FEEDER_LEVEL_EN
    chk("level", 32'(bus.level), 32'(q.size()));
`endif
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || busy || expect_at >= 0) && k < 3000) begin
      cycle(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("drain_done", {31'd0, k < 3000}, 32'd1);
  endtask

  initial begin
    int s;
    logic [7:0] rd;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 8'(i), 1'b0, i == 15, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    bus.tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (100) cycle(1'b0, 8'h00, 1'b0);
    chk("idle_no_start", nstarts, 0);

    s = nstarts;
    xd = 20;
    xh = 2;
    cycle(1'b1, 8'h55, 1'b0);
    repeat (40) cycle(1'b0, 8'h00, 1'b0);
    chk("single_start", nstarts - s, 1);
    chk("tx_byte_55_held", {24'd0, bus.tx_byte}, 32'h55);
    chk("empty_after_55", {31'd0, bus.empty}, 32'd1);

    xd = 80;
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].we, tbl[i].wd, tbl[i].clr);
      chk($sformatf("tbl%0d_full", i), {31'd0, bus.full},
          {31'd0, tbl[i].full});
      chk($sformatf("tbl%0d_empty", i), {31'd0, bus.empty},
          {31'd0, tbl[i].empty});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, bus.overflow},
          {31'd0, tbl[i].ovf});
    end
    xd = 5;
    s = nstarts;
    drain();
    chk("fifo_drain_starts", nstarts - s, 16);
    chk("last_byte_0f", {24'd0, bus.tx_byte}, 32'h0F);

    xd = 6;
    xh = 5;
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    chk("three_queued", q.size(), 3);
    drain();

    xd = 50;
    xh = 2;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    repeat (10) cycle(1'b0, 8'h00, 1'b0);
    chk("four_queued", q.size(), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    chk("arst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("arst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    model_reset();
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    s = nstarts;
    force_done = 1;
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    force_done = 0;
    repeat (20) cycle(1'b0, 8'h00, 1'b0);
    chk("stale_done_no_start", nstarts - s, 0);

    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      rd = 8'($urandom);
      cycle($urandom_range(0, 99) < 35, rd, $urandom_range(0, 99) < 4);
    end
    drain();
    rnd = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and launch controller sitting directly upstream of the UART transmitter. Tester logic pushes result bytes at core-clock speed; this block buffers them and hands them to the UART transmitter one at a time, using a start-pulse / done handshake so that no byte is lost or sent twice. Overflow is reported through a sticky flag rather than by back-pressuring the producer.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, 4..256.
- AW, $clog2(DEPTH), derived localparam; pointer width. Not overridable.

Ports:
- clk  input  1  system clock, 27 MHz nominal.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  push strobe; accepted only when full=0.
- wr_data  input  8  byte to push, sampled when wr_en=1.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- overflow  output  1  sticky; set by any wr_en while full=1.
- ovf_clr  input  1  clears overflow; set wins if both in same cycle.
- tx_byte  output  8  byte presented to the transmitter; stable from tx_start until tx_done.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_done  input  1  transmitter completion; high ≥1 cycle after the stop bit.
- level  output  AW+1  current fill count (only with UART_TX_FEEDER_LEVEL_EN).

## Operation
- Storage: DEPTH×8 register array; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. Count is a separate AW+1-bit register, 0..DEPTH.
- Push: wr_en=1 and full=0 → mem[wr_ptr]<=wr_data, wr_ptr++, count++. wr_en=1 with full=1 → data dropped, overflow<=1.
- Pop happens only inside the launch FSM (LAUNCH).
- Simultaneous push and pop: both take effect, count unchanged. Full is evaluated on the pre-edge count, so a push is dropped when full, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if count≠0 → LAUNCH.
  - LAUNCH: tx_byte<=mem[rd_ptr], rd_ptr++, count--, tx_start<=1 → WAIT_DONE.
  - WAIT_DONE: tx_start<=0; on tx_done=1 → RELEASE.
  - RELEASE: wait for tx_done=0 → IDLE. Absorbs the multi-cycle done pulse.
- tx_byte holds its last value outside transmissions.
- Reset (asynchronous, any state, including mid-byte): pointers=0, count=0, state=IDLE, tx_start=0, tx_byte=8'h00, overflow=0. Queued bytes are discarded. A tx_done arriving after reset is ignored because the FSM is in IDLE.

## Timing
- Reset values: full=0, empty=1, overflow=0, tx_start=0, tx_byte=8'h00, level=0.
- full, empty and level are decoded combinationally from the count register, so they update the cycle after the push or pop edge.
- Write-to-launch latency into an idle, empty block:
  - wr_en at edge N → count=1 after N.
  - FSM enters LAUNCH at N+1.
  - tx_start=1 and tx_byte valid during the cycle after edge N+2.
- tx_start is exactly 1 cycle wide. There is never more than one tx_start per tx_done high→low sequence.
- Back-to-back bytes: the next LAUNCH occurs ≥2 cycles after tx_done falls (RELEASE→IDLE→LAUNCH).
- tx_done high during IDLE or LAUNCH is ignored.
- Throughput is bounded by the transmitter, about 10×DELAY_FRAMES cycles per byte.

## Configuration
- UART_TX_FEEDER_LEVEL_EN defined: the level port exists and is driven from the count register.
- Not defined: the level port is absent and count is internal only. All other behaviour is identical.

## Test plan
- Reset → empty=1, full=0, tx_start=0, tx_byte=0x00, overflow=0; no tx_start for 100 cycles.
- Push 0x55 into an empty block, with the model transmitter returning tx_done 20 cycles after start for 2 cycles → single tx_start 2 cycles after the push, tx_byte=0x55, empty=1 afterwards.
- Push 0x00..0x0F back-to-back (DEPTH=16) → full=1 after the 16th push, provided no launch has popped yet. Bytes leave in order 0x00..0x0F, with exactly one tx_start per done pulse.
- Fill to full, then push 0xAA → byte dropped, overflow=1. Pulse ovf_clr → overflow=0. ovf_clr together with a dropped push → overflow stays 1.
- With 3 bytes queued, hold tx_done high for 5 cycles → no second tx_start until tx_done falls. Then the next byte launches 2 cycles later.
- Deassert rst_n while in WAIT_DONE with 4 bytes queued → immediate empty=1, tx_start=0. A subsequent stale tx_done pulse causes no launch.
